// File: rtl/ddfs_pkg.sv
// Shared constants and types for the ddfs frequency-sweep sequencer.
// Mode encodings match the 2-bit mode input; 2'b11 falls back to one-shot.
package ddfs_pkg;

  localparam int FCW_W = 23;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_SAW     = 2'b01;
  localparam logic [1:0] MODE_TRI     = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } sweep_state_t;

endpackage

// File: rtl/ddfs_dwell_cnt.sv
// Loadable down-counter that times how long each tuning word is held.
// o_expire is high while the count sits at zero, i.e. in the last cycle of a word.
module ddfs_dwell_cnt #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic          i_en,
  input  logic [DW-1:0] i_load_val,
  output logic          o_expire
);

  logic [DW-1:0] r_cnt;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples pre-edge values, independent of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - DW'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/ddfs_sweep.sv
// Linear-chirp sequencer driving the ddfs fcontrol tuning word: one-shot,
// sawtooth-repeat or triangle sweep between latched start/stop words.
module ddfs_sweep
  import ddfs_pkg::*;
#(
  parameter int FW = FCW_W,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [1:0]    mode,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_stop,
  input  logic [FW-1:0] f_step,
  input  logic [DW-1:0] dwell,
  output logic [FW-1:0] fcontrol,
  output logic          busy,
  output logic          done,
  output logic          wrap
);

  sweep_state_t r_state, w_state_nxt;

  logic [FW-1:0] r_fcontrol, w_fc_nxt;
  logic          r_busy, w_busy_nxt;
  logic          r_done, w_done_nxt;
  logic          r_wrap, w_wrap_nxt;

  logic [FW-1:0] r_start, r_stop, r_step;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_mode;

  logic          w_cfg_load;
  logic          w_cnt_load;
  logic          w_expire;
  logic [DW-1:0] w_cnt_val;
  logic [FW:0]   w_sum;
  logic [FW:0]   w_diff;
  logic [FW-1:0] w_up_word;
  logic [FW-1:0] w_dn_word;

  ddfs_dwell_cnt #(.DW(DW)) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_en       (r_state != IDLE),
    .i_load_val (w_cnt_val),
    .o_expire   (w_expire)
  );

  // The first word of a sweep is timed from the live input; later words from the latched copy.
  assign w_cnt_val = (r_state == IDLE) ? dwell : r_dwell;

  // One extra bit keeps the carry/borrow so clamping also catches wrap-around.
  assign w_sum     = {1'b0, r_fcontrol} + {1'b0, r_step};
  assign w_diff    = {1'b0, r_fcontrol} - {1'b0, r_step};
  assign w_up_word = (w_sum >= {1'b0, r_stop}) ? r_stop : w_sum[FW-1:0];
  assign w_dn_word = (w_diff[FW] || (w_diff[FW-1:0] <= r_start)) ? r_start : w_diff[FW-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the case statements can leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_fc_nxt    = r_fcontrol;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
    w_cfg_load  = 1'b0;
    w_cnt_load  = 1'b0;

    if (abort) begin
      w_state_nxt = IDLE;
      w_busy_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            w_cfg_load = 1'b1;
            w_cnt_load = 1'b1;
            w_fc_nxt   = f_start;
            if ((f_step == '0) || (f_stop <= f_start)) begin
              w_done_nxt = 1'b1;
            end else begin
              w_state_nxt = UP;
              w_busy_nxt  = 1'b1;
            end
          end
        end
        UP: begin
          if (w_expire) begin
            w_cnt_load = 1'b1;
            if (r_fcontrol == r_stop) begin
              unique case (r_mode)
                MODE_SAW: begin
                  w_fc_nxt   = r_start;
                  w_wrap_nxt = 1'b1;
                end
                MODE_TRI: begin
                  w_state_nxt = DOWN;
                  w_fc_nxt    = w_dn_word;
                  w_wrap_nxt  = (w_dn_word == r_start);
                end
                default: begin
                  w_state_nxt = IDLE;
                  w_busy_nxt  = 1'b0;
                  w_done_nxt  = 1'b1;
                end
              endcase
            end else begin
              w_fc_nxt = w_up_word;
            end
          end
        end
        DOWN: begin
          if (w_expire) begin
            w_cnt_load = 1'b1;
            if (r_fcontrol == r_start) begin
              w_state_nxt = UP;
              w_fc_nxt    = w_up_word;
            end else begin
              w_fc_nxt   = w_dn_word;
              w_wrap_nxt = (w_dn_word == r_start);
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fcontrol <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fcontrol <= w_fc_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_wrap     <= w_wrap_nxt;
    end
  end

  // NOTE: the config copies carry no reset; they are always written by the
  // start that launches a sweep before anything reads them.
  always_ff @(posedge clk) begin
    if (w_cfg_load) begin
      r_start <= f_start;
      r_stop  <= f_stop;
      r_step  <= f_step;
      r_dwell <= dwell;
      r_mode  <= mode;
    end
  end

  assign fcontrol = r_fcontrol;
  assign busy     = r_busy;
  assign done     = r_done;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_ddfs_sweep.sv
// Bench for ddfs_sweep: hand-written vector table, control corner cases and
// randomized sweeps scored against a word-level model of the chirp rules.
module tb_ddfs_sweep;
  import ddfs_pkg::*;

  localparam int FW = 23;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [1:0]    mode;
  logic [FW-1:0] f_start, f_stop, f_step;
  logic [DW-1:0] dwell;
  logic [FW-1:0] fcontrol;
  logic          busy, done, wrap;

  ddfs_sweep #(.FW(FW), .DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .abort    (abort),
    .mode     (mode),
    .f_start  (f_start),
    .f_stop   (f_stop),
    .f_step   (f_step),
    .dwell    (dwell),
    .fcontrol (fcontrol),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FW-1:0] fs, fe, st;
    logic [DW-1:0] dw;
    logic [1:0]    md;
    int            n;
    logic [FW-1:0] seq [12];
    logic [11:0]   wm;
  } vec_t;

  vec_t          vecs [6];
  int            n_cmp = 0;
  int            n_bad = 0;
  logic [FW-1:0] exp_w [$];
  bit            exp_wr [$];
  logic [FW-1:0] exp_last = '0;

  task automatic chkw(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    f_start = FW'($urandom());
    f_stop  = FW'($urandom());
    f_step  = FW'($urandom());
    dwell   = DW'($urandom());
    mode    = 2'($urandom());
  endtask

  task automatic do_start(input logic [FW-1:0] fs, input logic [FW-1:0] fe,
                          input logic [FW-1:0] st, input logic [DW-1:0] dw,
                          input logic [1:0] md);
    f_start = fs; f_stop = fe; f_step = st; dwell = dw; mode = md;
    start = 1'b1;
    tick();
    start = 1'b0;
    scramble();
  endtask

  // Word-level chirp model: list of the first m words and whether each arrives with wrap.
  task automatic build_model(input longint fs, input longint fe, input longint st,
                             input logic [1:0] md, input int m);
    longint w = fs;
    bit     down = 1'b0;
    bit     wr;
    exp_w.delete();
    exp_wr.delete();
    exp_w.push_back(FW'(w));
    exp_wr.push_back(1'b0);
    while (exp_w.size() < m) begin
      wr = 1'b0;
      if (!down) begin
        if (w == fe) begin
          if (md == MODE_SAW) begin
            w = fs; wr = 1'b1;
          end else if (md == MODE_TRI) begin
            down = 1'b1;
            w  = (fe - st > fs) ? fe - st : fs;
            wr = (w == fs);
          end else begin
            break;
          end
        end else begin
          w = (w + st < fe) ? w + st : fe;
        end
      end else begin
        if (w == fs) begin
          down = 1'b0;
          w = (w + st < fe) ? w + st : fe;
        end else begin
          w  = (w - st > fs) ? w - st : fs;
          wr = (w == fs);
        end
      end
      exp_w.push_back(FW'(w));
      exp_wr.push_back(wr);
    end
  endtask

  // Follows exp_w cycle by cycle; repeating sweeps are aborted on the last word's final edge.
  task automatic run_seq(input bit oneshot, input int d, input bit poke);
    int n = exp_w.size();
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c <= d; c++) begin
        chkw("fcontrol", fcontrol, exp_w[i]);
        chk1("busy", busy, 1'b1);
        chk1("done", done, 1'b0);
        chk1("wrap", wrap, (c == 0) && exp_wr[i]);
        if (poke && i == 1 && c == 0) start = 1'b1;
        if (!oneshot && i == n - 1 && c == d) abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
      end
    end
    exp_last = exp_w[n-1];
    if (oneshot) begin
      chk1("end_busy", busy, 1'b0);
      chk1("end_done", done, 1'b1);
      chkw("end_hold", fcontrol, exp_last);
      chk1("end_wrap", wrap, 1'b0);
      tick();
      chk1("done_pulse", done, 1'b0);
      chkw("end_hold2", fcontrol, exp_last);
    end else begin
      chk1("abort_busy", busy, 1'b0);
      chk1("abort_done", done, 1'b0);
      chk1("abort_wrap", wrap, 1'b0);
      chkw("abort_freeze", fcontrol, exp_last);
      tick();
      tick();
      chkw("abort_freeze2", fcontrol, exp_last);
      chk1("abort_busy2", busy, 1'b0);
      chk1("abort_done2", done, 1'b0);
    end
  endtask

  task automatic set_vec(input int k, input logic [FW-1:0] fs, input logic [FW-1:0] fe,
                         input logic [FW-1:0] st, input logic [DW-1:0] dw,
                         input logic [1:0] md, input int n, input logic [11:0] wm);
    vecs[k].fs = fs; vecs[k].fe = fe; vecs[k].st = st;
    vecs[k].dw = dw; vecs[k].md = md; vecs[k].n = n; vecs[k].wm = wm;
  endtask

  initial begin
    logic [FW-1:0] fs, fe, st;
    logic [DW-1:0] dw;
    logic [1:0]    md;
    int            span;

    set_vec(0, 23'h001000, 23'h001400, 23'h000100, 16'd3, 2'b00, 5, 12'h000);
    vecs[0].seq = '{23'h1000, 23'h1100, 23'h1200, 23'h1300, 23'h1400,
                    23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0};
    set_vec(1, 23'h001000, 23'h001250, 23'h000100, 16'd1, 2'b11, 4, 12'h000);
    vecs[1].seq = '{23'h1000, 23'h1100, 23'h1200, 23'h1250,
                    23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0};
    set_vec(2, 23'h7FFF00, 23'h7FFFFF, 23'h400000, 16'd2, 2'b00, 2, 12'h000);
    vecs[2].seq = '{23'h7FFF00, 23'h7FFFFF,
                    23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0, 23'h0};
    set_vec(3, 23'h030000, 23'h030300, 23'h000100, 16'd0, 2'b10, 12, 12'h040);
    vecs[3].seq = '{23'h30000, 23'h30100, 23'h30200, 23'h30300, 23'h30200, 23'h30100,
                    23'h30000, 23'h30100, 23'h30200, 23'h30300, 23'h30200, 23'h30100};
    set_vec(4, 23'h030000, 23'h030300, 23'h000100, 16'd0, 2'b01, 12, 12'h110);
    vecs[4].seq = '{23'h30000, 23'h30100, 23'h30200, 23'h30300, 23'h30000, 23'h30100,
                    23'h30200, 23'h30300, 23'h30000, 23'h30100, 23'h30200, 23'h30300};
    set_vec(5, 23'h000100, 23'h000350, 23'h000100, 16'd1, 2'b10, 12, 12'h040);
    vecs[5].seq = '{23'h100, 23'h200, 23'h300, 23'h350, 23'h250, 23'h150,
                    23'h100, 23'h200, 23'h300, 23'h350, 23'h250, 23'h150};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0; mode = '0;
    tick();
    tick();
    chkw("rst_fcontrol", fcontrol, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_wrap", wrap, 1'b0);
    rst = 1'b0;
    tick();

    // Table vectors; the first also pulses start mid-sweep, which must be ignored.
    for (int k = 0; k < 6; k++) begin
      exp_w.delete();
      exp_wr.delete();
      for (int j = 0; j < vecs[k].n; j++) begin
        exp_w.push_back(vecs[k].seq[j]);
        exp_wr.push_back(vecs[k].wm[j]);
      end
      do_start(vecs[k].fs, vecs[k].fe, vecs[k].st, vecs[k].dw, vecs[k].md);
      run_seq((vecs[k].md != MODE_SAW) && (vecs[k].md != MODE_TRI), int'(vecs[k].dw), k == 0);
      tick();
    end

    // start together with abort: stays idle, nothing changes.
    f_start = 23'h000500; f_stop = 23'h000900; f_step = 23'h000100; dwell = '0; mode = 2'b00;
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk1("sa_busy", busy, 1'b0);
    chk1("sa_done", done, 1'b0);
    chkw("sa_fcontrol", fcontrol, exp_last);
    tick();
    chk1("sa_busy2", busy, 1'b0);

    // Degenerate configs: zero step, stop equal to start, stop below start.
    do_start(23'h002000, 23'h003000, 23'h000000, 16'd2, 2'b10);
    chkw("step0_fc", fcontrol, 23'h002000);
    chk1("step0_done", done, 1'b1);
    chk1("step0_busy", busy, 1'b0);
    tick();
    chk1("step0_done2", done, 1'b0);
    chk1("step0_busy2", busy, 1'b0);
    do_start(23'h005000, 23'h005000, 23'h000010, 16'd0, 2'b01);
    chk1("eq_done", done, 1'b1);
    chk1("eq_busy", busy, 1'b0);
    tick();
    do_start(23'h006000, 23'h005000, 23'h000010, 16'd0, 2'b00);
    chkw("lt_fc", fcontrol, 23'h006000);
    chk1("lt_done", done, 1'b1);
    chk1("lt_busy", busy, 1'b0);
    tick();

    // Abort in the middle of a word: word frozen, no done.
    do_start(23'h001000, 23'h001400, 23'h000100, 16'd3, 2'b00);
    for (int i = 0; i < 5; i++) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk1("mabort_busy", busy, 1'b0);
    chkw("mabort_fc", fcontrol, 23'h001100);
    for (int i = 0; i < 6; i++) begin
      chk1("mabort_nodone", done, 1'b0);
      tick();
    end
    chkw("mabort_fc2", fcontrol, 23'h001100);

    // Reset in the middle of a triangle sweep.
    do_start(23'h001000, 23'h002000, 23'h000100, 16'd2, 2'b10);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    chkw("mrst_fcontrol", fcontrol, '0);
    chk1("mrst_busy", busy, 1'b0);
    chk1("mrst_done", done, 1'b0);
    chk1("mrst_wrap", wrap, 1'b0);
    rst = 1'b0;
    tick();
    chk1("mrst_busy2", busy, 1'b0);
    chkw("mrst_fcontrol2", fcontrol, '0);

    // Randomized sweeps against the word-level model.
    for (int it = 0; it < 24; it++) begin
      md   = 2'($urandom_range(0, 3));
      dw   = DW'($urandom_range(0, 3));
      span = int'($urandom_range(1, 3000));
      if (it % 4 == 3) begin
        fs = FW'(23'h7FF000 + $urandom_range(0, 23'h000F00));
        fe = 23'h7FFFFF;
        st = FW'(23'h400000 + $urandom_range(0, 23'h3FFFFF));
      end else begin
        fs = FW'($urandom_range(0, 23'h7FF000));
        fe = fs + FW'(span);
        st = FW'($urandom_range(span / 16 + 1, span + 40));
      end
      if (md == MODE_SAW || md == MODE_TRI)
        build_model(longint'(fs), longint'(fe), longint'(st), md, int'($urandom_range(8, 20)));
      else
        build_model(longint'(fs), longint'(fe), longint'(st), md, 100000);
      do_start(fs, fe, st, dw, md);
      run_seq((md != MODE_SAW) && (md != MODE_TRI), int'(dw), (it % 3 == 0) && (exp_w.size() >= 2));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
